// File: rtl/sd_img_load_sched.sv
// Streams one RTL-selected 640x480 RGB565 image from SD into DDR as serial sector reads.
// Optional slideshow dwell timer enabled by SD_IMG_AUTOPLAY_EN.
module sd_img_load_sched #(
  parameter logic [31:0] BASE_SECTOR = 32'd16640,
  parameter int          IMG_SECTORS = 1200,
  parameter int          IMG_NUM     = 4,
  parameter int          IDX_W       = 2,
  parameter logic [15:0] TIMEOUT     = 16'd4095
`ifdef SD_IMG_AUTOPLAY_EN
  , parameter logic [31:0] AUTO_CYCLES = 32'd75000000
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             init_end,
  input  logic             next_img,
  input  logic             prev_img,
  input  logic             rd_busy,
  output logic             rd_en,
  output logic [31:0]      rd_addr,
  output logic             ddr_wr_rst,
  output logic [IDX_W-1:0] img_idx,
  output logic             load_busy,
  output logic             load_done,
  output logic [7:0]       timeout_cnt
);

  localparam int CNT_W = $clog2(IMG_SECTORS);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_RST, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] target_q, target_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             loaded_q, loaded_d;
  logic             auto_adv;
  logic             adv, back;

`ifdef SD_IMG_AUTOPLAY_EN
  logic [31:0] dwell_q, dwell_d;

  // Dwell only counts while parked on a finished image; any key press restarts it.
  always_comb begin
    dwell_d  = 32'd0;
    auto_adv = 1'b0;
    if (state_q == S_IDLE && loaded_q && init_end && !(next_img || prev_img)) begin
      if (dwell_q == AUTO_CYCLES - 32'd1) begin
        auto_adv = 1'b1;
      end else begin
        dwell_d = dwell_q + 32'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) dwell_q <= 32'd0;
    else            dwell_q <= dwell_d;
  end
`else
  assign auto_adv = 1'b0;
`endif

  assign adv  = (next_img && !prev_img) || auto_adv;
  assign back = prev_img && !next_img;

  always_comb begin
    target_d = target_q;
    if (adv) begin
      target_d = (target_q == IDX_W'(IMG_NUM - 1)) ? '0 : target_q + 1'b1;
    end else if (back) begin
      target_d = (target_q == '0) ? IDX_W'(IMG_NUM - 1) : target_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    tcnt_d   = tcnt_q;
    loaded_d = loaded_q;
    if (!init_end) begin
      state_d  = S_IDLE;
      loaded_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!loaded_q || target_q != idx_q) state_d = S_WR_RST;
        end
        S_WR_RST: begin
          idx_d    = target_q;
          cnt_d    = '0;
          loaded_d = 1'b1;
          addr_d   = BASE_SECTOR + 32'(target_q) * 32'(IMG_SECTORS);
          state_d  = S_ISSUE;
        end
        S_ISSUE: begin
          tmo_d   = 16'd0;
          state_d = S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (rd_busy) begin
            state_d = S_WAIT_LO;
          end else if (tmo_q == TIMEOUT - 16'd1) begin
            // Re-issue the same sector; addr_q is left untouched.
            tcnt_d  = (tcnt_q != 8'hFF) ? tcnt_q + 8'd1 : tcnt_q;
            state_d = S_ISSUE;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        S_WAIT_LO: begin
          if (!rd_busy) begin
            if (cnt_q == CNT_W'(IMG_SECTORS - 1)) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              addr_d  = addr_q + 32'd1;
              state_d = S_ISSUE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= 16'd0;
      addr_q   <= 32'd0;
      tcnt_q   <= 8'd0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      tcnt_q   <= tcnt_d;
      loaded_q <= loaded_d;
    end
  end

  assign rd_en       = (state_q == S_ISSUE);
  assign ddr_wr_rst  = (state_q == S_WR_RST);
  assign load_done   = (state_q == S_DONE);
  assign load_busy   = (state_q == S_WR_RST) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
  assign rd_addr     = addr_q;
  assign img_idx     = idx_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_sd_img_load_sched.sv
// Bench for sd_img_load_sched: randomized sd_ctrl busy timing, expected sector streams from image arithmetic.
module tb_sd_img_load_sched;
  localparam logic [31:0] BASE = 32'd16640;
  localparam int IMGS = 1200;
  localparam int NUM = 4;
  localparam int TMO = 4095;
  localparam int LOAD_BUDGET = 20000;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, init_end = 1'b0;
  logic next_img = 1'b0, prev_img = 1'b0, rd_busy = 1'b0;
  logic rd_en, ddr_wr_rst, load_busy, load_done;
  logic [31:0] rd_addr;
  logic [1:0] img_idx;
  logic [7:0] timeout_cnt;

  int checks = 0, errors = 0, cyc = 0;
  int wr_rst_cnt = 0, done_cnt = 0, drop_cnt = 0;
  int busy_dly = 0, busy_len = 0, last_done_cyc = 0, last_wr_cyc = 0;
  logic [31:0] addrs[$];
  int en_cyc[$];
  bit drop_arm = 1'b0;
  logic [31:0] drop_addr = 32'd0;
  int exp_tgt = 0;

  always #20 sys_clk = ~sys_clk;

  sd_img_load_sched #(
    .BASE_SECTOR(BASE), .IMG_SECTORS(IMGS), .IMG_NUM(NUM), .IDX_W(2), .TIMEOUT(16'd4095)
`ifdef SD_IMG_AUTOPLAY_EN
    , .AUTO_CYCLES(32'd1000)
`endif
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
    .next_img(next_img), .prev_img(prev_img), .rd_busy(rd_busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .ddr_wr_rst(ddr_wr_rst), .img_idx(img_idx),
    .load_busy(load_busy), .load_done(load_done), .timeout_cnt(timeout_cnt)
  );

  // Event recorder plus sd_ctrl model: busy rises 0..2 cycles after rd_en, stays 3..4 cycles.
  always @(negedge sys_clk) begin
    cyc++;
    if (ddr_wr_rst) begin wr_rst_cnt++; last_wr_cyc = cyc; end
    if (load_done) begin done_cnt++; last_done_cyc = cyc; end
    if (rd_en) begin
      addrs.push_back(rd_addr);
      en_cyc.push_back(cyc);
      if (drop_arm && drop_cnt == 0 && rd_addr == drop_addr) drop_cnt++;
      else begin
        busy_dly = $urandom_range(2, 0);
        busy_len = $urandom_range(4, 3);
      end
    end
    if (busy_dly > 0) begin rd_busy = 1'b0; busy_dly--; end
    else if (busy_len > 0) begin rd_busy = 1'b1; busy_len--; end
    else rd_busy = 1'b0;
  end

  function automatic int nxt(input int i); return (i + 1) % NUM; endfunction
  function automatic int prv(input int i); return (i + NUM - 1) % NUM; endfunction
  function automatic logic [31:0] exp_addr(input int idx, input int s);
    return BASE + 32'(idx * IMGS + s);
  endfunction
  function automatic logic [31:0] q_at(input int i);
    if (i < addrs.size()) return addrs[i];
    return 32'hFFFF_FFFF;
  endfunction
  function automatic int count_bad(input int b, input int idx, input int s0, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (q_at(b + i) !== exp_addr(idx, s0 + i)) bad++;
    return bad;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
  endtask
  task automatic pulse(input bit nx, input bit pv);
    @(posedge sys_clk); #1; next_img = nx; prev_img = pv;
    @(posedge sys_clk); #1; next_img = 1'b0; prev_img = 1'b0;
  endtask
  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LOAD_BUDGET; i++) begin
      @(negedge sys_clk);
      if (done_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask
  task automatic wait_size(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LOAD_BUDGET; i++) begin
      @(negedge sys_clk);
      if (addrs.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; init_end = 1'b1;
    tick(5); @(negedge sys_clk);
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b expected 0", rd_en); end
    checks++; if (rd_addr !== 32'd0) begin errors++; $display("FAIL rst_rd_addr: got %0d expected 0", rd_addr); end
    checks++; if (ddr_wr_rst !== 1'b0) begin errors++; $display("FAIL rst_wr_rst: got %0b expected 0", ddr_wr_rst); end
    checks++; if (img_idx !== 2'd0) begin errors++; $display("FAIL rst_img_idx: got %0d expected 0", img_idx); end
    checks++; if (load_busy !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %0b%0b expected 00", load_busy, load_done); end
    checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL rst_timeout_cnt: got %0d expected 0", timeout_cnt); end
  endtask

  task automatic test_first_load();
    int b = addrs.size(), w0 = wr_rst_cnt, d0 = done_cnt;
    bit ok;
    @(posedge sys_clk); #1; sys_rst_n = 1'b1;
    wait_done(d0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_done: got no load_done, expected one within %0d cycles", LOAD_BUDGET); end
    checks++; if (addrs.size() - b !== IMGS) begin errors++; $display("FAIL first_count: got %0d rd_en expected %0d", addrs.size() - b, IMGS); end
    checks++; if (count_bad(b, 0, 0, IMGS) !== 0) begin errors++; $display("FAIL first_seq: got %0d bad addrs expected 0", count_bad(b, 0, 0, IMGS)); end
    checks++; if (img_idx !== 2'd0) begin errors++; $display("FAIL first_idx: got %0d expected 0", img_idx); end
    tick(20); @(negedge sys_clk);
    checks++; if (wr_rst_cnt - w0 !== 1) begin errors++; $display("FAIL first_wr_rst: got %0d expected 1", wr_rst_cnt - w0); end
    checks++; if (done_cnt - d0 !== 1 || load_busy !== 1'b0) begin errors++; $display("FAIL first_idle: got done=%0d busy=%0b expected 1,0", done_cnt - d0, load_busy); end
  endtask

  task automatic test_key_wrap();
    int b, d0;
    bit ok;
    b = addrs.size(); d0 = done_cnt; exp_tgt = prv(exp_tgt);
    pulse(1'b0, 1'b1);
    wait_done(d0 + 1, ok);
    checks++; if (!ok || img_idx !== 2'(exp_tgt)) begin errors++; $display("FAIL wrap_prev_idx: got %0d expected %0d", img_idx, exp_tgt); end
    checks++; if (q_at(b) !== 32'd20240) begin errors++; $display("FAIL wrap_prev_addr: got %0d expected 20240", q_at(b)); end
    checks++; if (count_bad(b, exp_tgt, 0, IMGS) !== 0 || addrs.size() - b !== IMGS) begin errors++; $display("FAIL wrap_prev_seq: got %0d addrs expected %0d clean", addrs.size() - b, IMGS); end
    b = addrs.size(); d0 = done_cnt; exp_tgt = nxt(exp_tgt);
    pulse(1'b1, 1'b0);
    wait_done(d0 + 1, ok);
    checks++; if (!ok || img_idx !== 2'(exp_tgt)) begin errors++; $display("FAIL wrap_next_idx: got %0d expected %0d", img_idx, exp_tgt); end
    checks++; if (q_at(b) !== 32'd16640) begin errors++; $display("FAIL wrap_next_addr: got %0d expected 16640", q_at(b)); end
  endtask

  task automatic test_collapse();
    int b = addrs.size(), w0 = wr_rst_cnt, d0 = done_cnt, w1;
    bit ok;
    @(posedge sys_clk); #1; init_end = 1'b0;
    tick(2); #1; init_end = 1'b1;
    wait_size(b + 501, ok);
    pulse(1'b1, 1'b0); tick(3); pulse(1'b1, 1'b0);
    exp_tgt = nxt(nxt(exp_tgt));
    wait_done(d0 + 1, ok);
    checks++; if (!ok || img_idx !== 2'd0) begin errors++; $display("FAIL collapse_cur_idx: got %0d expected 0", img_idx); end
    checks++; if (count_bad(b, 0, 0, IMGS) !== 0) begin errors++; $display("FAIL collapse_cur_seq: got %0d bad addrs expected 0", count_bad(b, 0, 0, IMGS)); end
    wait_done(d0 + 2, ok);
    checks++; if (!ok || img_idx !== 2'(exp_tgt)) begin errors++; $display("FAIL collapse_idx: got %0d expected %0d", img_idx, exp_tgt); end
    checks++; if (q_at(b + IMGS) !== 32'd19040) begin errors++; $display("FAIL collapse_addr: got %0d expected 19040", q_at(b + IMGS)); end
    checks++; if (wr_rst_cnt - w0 !== 2) begin errors++; $display("FAIL collapse_loads: got %0d expected 2", wr_rst_cnt - w0); end
    w1 = wr_rst_cnt;
    pulse(1'b1, 1'b1);
    tick(30); @(negedge sys_clk);
    checks++; if (wr_rst_cnt !== w1 || img_idx !== 2'(exp_tgt)) begin errors++; $display("FAIL both_keys: got loads=%0d idx=%0d expected 0,%0d", wr_rst_cnt - w1, img_idx, exp_tgt); end
  endtask

  task automatic test_timeout();
    int b = addrs.size(), d0 = done_cnt, gap;
    bit ok, dir;
    dir = 1'($urandom_range(1, 0));
    exp_tgt = dir ? nxt(exp_tgt) : prv(exp_tgt);
    drop_addr = exp_addr(exp_tgt, 7); drop_arm = 1'b1;
    pulse(dir, !dir);
    wait_done(d0 + 1, ok);
    drop_arm = 1'b0;
    checks++; if (!ok || addrs.size() - b !== IMGS + 1) begin errors++; $display("FAIL tmo_count: got %0d rd_en expected %0d", addrs.size() - b, IMGS + 1); end
    checks++; if (q_at(b + 7) !== drop_addr || q_at(b + 8) !== drop_addr) begin errors++; $display("FAIL tmo_same_addr: got %0d,%0d expected %0d", q_at(b + 7), q_at(b + 8), drop_addr); end
    gap = (en_cyc.size() > b + 8) ? en_cyc[b + 8] - en_cyc[b + 7] : -1;
    checks++; if (gap < TMO || gap > TMO + 2) begin errors++; $display("FAIL tmo_gap: got %0d cycles expected %0d..%0d", gap, TMO, TMO + 2); end
    checks++; if (timeout_cnt !== 8'd1) begin errors++; $display("FAIL tmo_cnt: got %0d expected 1", timeout_cnt); end
    checks++; if (count_bad(b, exp_tgt, 0, 8) + count_bad(b + 8, exp_tgt, 7, IMGS - 7) !== 0) begin errors++; $display("FAIL tmo_seq: got bad sequence for image %0d expected clean", exp_tgt); end
  endtask

  task automatic test_init_drop();
    int b = addrs.size(), s1, w0, d0;
    bit ok;
    exp_tgt = nxt(exp_tgt);
    pulse(1'b1, 1'b0);
    wait_size(b + 301, ok);
    @(posedge sys_clk); #1; init_end = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
    checks++; if (rd_en !== 1'b0 || ddr_wr_rst !== 1'b0 || load_busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got en=%0b rst=%0b busy=%0b expected 000", rd_en, ddr_wr_rst, load_busy); end
    s1 = addrs.size();
    tick(9); @(negedge sys_clk);
    checks++; if (addrs.size() !== s1) begin errors++; $display("FAIL drop_quiet: got %0d reads expected 0", addrs.size() - s1); end
    w0 = wr_rst_cnt; d0 = done_cnt; b = addrs.size();
    @(posedge sys_clk); #1; init_end = 1'b1;
    wait_done(d0 + 1, ok);
    checks++; if (!ok || wr_rst_cnt - w0 !== 1) begin errors++; $display("FAIL drop_reload_rst: got %0d expected 1", wr_rst_cnt - w0); end
    checks++; if (addrs.size() - b !== IMGS || count_bad(b, exp_tgt, 0, IMGS) !== 0) begin errors++; $display("FAIL drop_reload_seq: got %0d addrs first %0d expected %0d from %0d", addrs.size() - b, q_at(b), IMGS, exp_addr(exp_tgt, 0)); end
    checks++; if (img_idx !== 2'(exp_tgt)) begin errors++; $display("FAIL drop_reload_idx: got %0d expected %0d", img_idx, exp_tgt); end
  endtask

  task automatic test_idle_dwell();
    int w0 = wr_rst_cnt, d0 = done_cnt;
`ifdef SD_IMG_AUTOPLAY_EN
    bit ok;
    int gap;
    for (int i = 0; i < 2000 && wr_rst_cnt == w0; i++) @(negedge sys_clk);
    gap = last_wr_cyc - last_done_cyc;
    checks++; if (wr_rst_cnt == w0 || gap < 1000 || gap > 1004) begin errors++; $display("FAIL auto_gap: got %0d cycles expected 1000..1004", gap); end
    exp_tgt = nxt(exp_tgt);
    wait_done(d0 + 1, ok);
    checks++; if (!ok || img_idx !== 2'(exp_tgt)) begin errors++; $display("FAIL auto_idx: got %0d expected %0d", img_idx, exp_tgt); end
`else
    tick(2000); @(negedge sys_clk);
    checks++; if (wr_rst_cnt !== w0 || done_cnt !== d0 || img_idx !== 2'(exp_tgt)) begin errors++; $display("FAIL no_auto: got loads=%0d idx=%0d expected 0,%0d", wr_rst_cnt - w0, img_idx, exp_tgt); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_key_wrap();
    test_collapse();
    test_timeout();
    test_init_drop();
    test_idle_dwell();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
